// File: rtl/jt51_exp_arb.sv
// Round-robin arbiter that time-shares one exp ROM among NREQ requesters.
// Grant, ROM lookup and shift form a 3-stage pipeline advanced by cen.
module jt51_exp_arb #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = 2,
   parameter int unsigned LW   = 12
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cen,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*LW-1:0]   log_in,
   output logic [NREQ-1:0]      gnt,
   output logic [7:0]           rom_addr,
   input  logic [15:0]          rom_data,
   output logic                 out_valid,
   output logic [IDW-1:0]       out_id,
   output logic [15:0]          out_lin
);

   localparam int unsigned SW = LW - 8;

   logic [IDW-1:0]  r_ptr;
   logic [NREQ-1:0] r_gnt;
   logic [7:0]      r_rom_addr;
   logic            r_s1_v;
   logic [SW-1:0]   r_s1_shift;
   logic [IDW-1:0]  r_s1_id;
   logic            r_s2_v;
   logic [SW-1:0]   r_s2_shift;
   logic [IDW-1:0]  r_s2_id;
   logic            r_out_valid;
   logic [IDW-1:0]  r_out_id;
   logic [15:0]     r_out_lin;

   logic [NREQ-1:0] w_elig;
   logic            w_found;
   logic [IDW-1:0]  w_win;
   logic [IDW-1:0]  w_next_ptr;
   logic [LW-1:0]   w_log;

   // Search eligible requesters from r_ptr upward, wrapping; the current grantee is excluded
   always_comb begin
      int unsigned v_idx;
      v_idx   = 0;
      w_found = 1'b0;
      w_win   = '0;
      w_elig  = req & ~r_gnt;
      for (int unsigned k = 0; k < NREQ; k++) begin
         v_idx = 32'(r_ptr) + k;
         if (v_idx >= NREQ) v_idx = v_idx - NREQ;
         if (!w_found && w_elig[v_idx]) begin
            w_found = 1'b1;
            w_win   = IDW'(v_idx);
         end
      end
   end

   assign w_next_ptr = (w_win == IDW'(NREQ - 1)) ? '0 : w_win + IDW'(1);
   assign w_log      = log_in[32'(w_win)*LW +: LW];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ptr       <= '0;
         r_gnt       <= '0;
         r_rom_addr  <= '0;
         r_s1_v      <= 1'b0;
         r_s1_shift  <= '0;
         r_s1_id     <= '0;
         r_s2_v      <= 1'b0;
         r_s2_shift  <= '0;
         r_s2_id     <= '0;
         r_out_valid <= 1'b0;
         r_out_id    <= '0;
         r_out_lin   <= '0;
      end else if (cen) begin
         r_gnt  <= w_found ? (NREQ'(1) << w_win) : '0;
         r_s1_v <= w_found;
         if (w_found) begin
            r_rom_addr <= w_log[7:0];
            r_s1_shift <= w_log[LW-1:8];
            r_s1_id    <= w_win;
            r_ptr      <= w_next_ptr;
         end
         // ROM latches rom_addr on this same edge, so s2 lines up with rom_data next edge
         r_s2_v      <= r_s1_v;
         r_s2_shift  <= r_s1_shift;
         r_s2_id     <= r_s1_id;
         r_out_valid <= r_s2_v;
         if (r_s2_v) begin
            r_out_lin <= rom_data >> r_s2_shift;
            r_out_id  <= r_s2_id;
         end
      end
   end

   assign gnt       = r_gnt;
   assign rom_addr  = r_rom_addr;
   assign out_valid = r_out_valid;
   assign out_id    = r_out_id;
   assign out_lin   = r_out_lin;

endmodule

// File: tb/tb_jt51_exp_arb.sv
// Scoreboard bench for jt51_exp_arb: a reference arbiter pushes expected results
// at each grant; they are popped when the DUT raises out_valid.
module tb_jt51_exp_arb;

   localparam int unsigned NREQ = 4;
   localparam int unsigned IDW  = 2;
   localparam int unsigned LW   = 12;

   typedef struct packed {
      logic [IDW-1:0] id;
      logic [15:0]    lin;
   } exp_t;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                cen = 1'b1;
   logic [NREQ-1:0]     req = '0;
   logic [NREQ*LW-1:0]  log_in = '0;
   logic [NREQ-1:0]     gnt;
   logic [7:0]          rom_addr;
   logic [15:0]         rom_data = '0;
   logic                out_valid;
   logic [IDW-1:0]      out_id;
   logic [15:0]         out_lin;

   int n_checks = 0;
   int n_fail   = 0;
   int cen_div  = 1;
   int cen_cnt  = 0;
   bit chk_en   = 1'b0;

   exp_t            sb_q[$];
   logic [NREQ-1:0] m_gnt;
   logic [7:0]      m_addr;
   int              m_ptr;
   logic            m_v1, m_v2, m_ov, m_edge;
   logic [IDW-1:0]  m_id;
   logic [15:0]     m_lin;
   logic            m_found;
   int              m_w;
   logic [LW-1:0]   m_lv;
   exp_t            m_e;

   jt51_exp_arb #(.NREQ(NREQ), .IDW(IDW), .LW(LW)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cen       (cen),
      .req       (req),
      .log_in    (log_in),
      .gnt       (gnt),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .out_valid (out_valid),
      .out_id    (out_id),
      .out_lin   (out_lin)
   );

   always #5 clk = ~clk;

   // Stand-in exp table: only entries 0x00 and 0xff are pinned to known values
   function automatic logic [15:0] exp_val(input logic [7:0] a);
      if (a == 8'hff) return 16'h0000;
      return 16'hfe9e - 16'(a) * 16'd251;
   endfunction

   always @(posedge clk) if (cen) rom_data <= exp_val(rom_addr);

   initial begin
      forever begin
         @(posedge clk);
         #1;
         cen_cnt = (cen_cnt + 1 >= cen_div) ? 0 : cen_cnt + 1;
         cen     = (cen_cnt == 0);
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Reference arbiter and pipeline timing
   always @(posedge clk) begin
      m_edge = 1'b0;
      if (!rst_n) begin
         m_gnt = '0; m_addr = '0; m_ptr = 0;
         m_v1 = 1'b0; m_v2 = 1'b0; m_ov = 1'b0;
         m_id = '0; m_lin = '0;
         sb_q.delete();
      end else if (cen) begin
         m_edge  = 1'b1;
         m_ov    = m_v2;
         m_v2    = m_v1;
         m_found = 1'b0;
         m_w     = 0;
         for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NREQ;
            if (!m_found && req[idx] && !m_gnt[idx]) begin
               m_found = 1'b1;
               m_w     = idx;
            end
         end
         m_gnt = '0;
         m_v1  = m_found;
         if (m_found) begin
            m_lv       = log_in[m_w*LW +: LW];
            m_gnt[m_w] = 1'b1;
            m_addr     = m_lv[7:0];
            m_ptr      = (m_w + 1) % NREQ;
            m_e.id     = IDW'(m_w);
            m_e.lin    = exp_val(m_lv[7:0]) >> m_lv[LW-1:8];
            sb_q.push_back(m_e);
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check_eq("gnt", 32'(gnt), 32'(m_gnt));
         check_eq("out_valid", 32'(out_valid), 32'(m_ov));
         check_eq("rom_addr", 32'(rom_addr), 32'(m_addr));
         if (m_edge && out_valid) begin
            if (sb_q.size() == 0) begin
               check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
            end else begin
               m_e = sb_q.pop_front();
               check_eq("out_id", 32'(out_id), 32'(m_e.id));
               check_eq("out_lin", 32'(out_lin), 32'(m_e.lin));
               m_id  = m_e.id;
               m_lin = m_e.lin;
            end
         end else begin
            check_eq("out_id_hold", 32'(out_id), 32'(m_id));
            check_eq("out_lin_hold", 32'(out_lin), 32'(m_lin));
         end
      end
   end

   task automatic wait_cen(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         while (!cen) @(posedge clk);
      end
      #2;
   endtask

   task automatic set_log(input int idx, input logic [LW-1:0] v);
      log_in[idx*LW +: LW] = v;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      @(posedge clk);
      #2;
      chk_en = 1'b1;
      check_eq("rst_gnt", 32'(gnt), 32'd0);
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_out_lin", 32'(out_lin), 32'd0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;

      // single request, no shift
      set_log(2, 12'h000);
      req = 4'b0100;
      wait_cen(1);
      check_eq("single_gnt", 32'(gnt), 32'h4);
      req = 4'b0000;
      wait_cen(2);
      check_eq("single_valid", 32'(out_valid), 32'd1);
      check_eq("single_id", 32'(out_id), 32'd2);
      check_eq("single_lin", 32'(out_lin), 32'hfe9e);

      // shift by 1
      set_log(0, 12'h100);
      req = 4'b0001;
      wait_cen(1);
      req = 4'b0000;
      wait_cen(2);
      check_eq("shift1_lin", 32'(out_lin), 32'h7f4f);

      // shift by 2 of a zero ROM word
      set_log(0, 12'h2ff);
      req = 4'b0001;
      wait_cen(1);
      req = 4'b0000;
      wait_cen(2);
      check_eq("shift2_id", 32'(out_id), 32'd0);
      check_eq("shift2_lin", 32'(out_lin), 32'h0000);

      // all four requesters held high
      set_log(0, 12'h010);
      set_log(1, 12'h120);
      set_log(2, 12'h340);
      set_log(3, 12'hf05);
      req = 4'b1111;
      wait_cen(12);
      req = 4'b0000;
      wait_cen(3);
      check_eq("rr_drain", 32'(sb_q.size()), 32'd0);

      // same stimulus with cen one clk in four
      cen_div = 4;
      req = 4'b1111;
      wait_cen(12);
      req = 4'b0000;
      wait_cen(3);
      check_eq("cen4_drain", 32'(sb_q.size()), 32'd0);
      cen_div = 1;
      wait_cen(1);

      // reset with two lookups in flight
      req = 4'b1111;
      wait_cen(2);
      rst_n = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      req = 4'b1010;
      wait_cen(1);
      check_eq("rst_first_gnt", 32'(gnt), 32'h2);
      check_eq("rst_valid_e1", 32'(out_valid), 32'd0);
      wait_cen(1);
      check_eq("rst_valid_e2", 32'(out_valid), 32'd0);
      wait_cen(4);
      req = 4'b0000;
      wait_cen(3);

      // idle: nothing granted, outputs hold
      for (int i = 0; i < 10; i++) begin
         wait_cen(1);
         check_eq("idle_gnt", 32'(gnt), 32'd0);
         check_eq("idle_valid", 32'(out_valid), 32'd0);
         check_eq("idle_lin", 32'(out_lin), 32'(m_lin));
         check_eq("idle_addr", 32'(rom_addr), 32'(m_addr));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
